clk_time_ctrl: RTL and testbench

//  Run/set controller for the digital-clock time chain (sec/min/hour BCD counters).
//  In RUN it divides clk down to a 1 Hz single-cycle enable for the seconds counter.
//  In SET it freezes counting and drives each counter's load/data_in for manual editing.
//  The counters' data_out values are fed back to it. It sits between the key debouncers
//  and the counter chain.

---
 rtl/clk_ctrl_pkg.sv | 16 +
 rtl/tick_div.sv | 17 +
 rtl/clk_time_ctrl.sv | 62 ++++++
 tb/tb_clk_time_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: mode encodings, field limits and BCD increment for the clock controller
package clk_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v == max) ? 8'h00 :
           (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/tick_div.sv
// tick_div: clearable divider; tick is high during the last cycle of each DIV-cycle period
module tick_div #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  always_comb tick = en && !clr && cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/clk_time_ctrl.sv
// clk_time_ctrl: run/set controller feeding sec_en and load strobes to the BCD time chain
module clk_time_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_key,
  input  logic       inc_key,
  input  logic [7:0] sec_q,
  input  logic [7:0] min_q,
  input  logic [7:0] hour_q,
  output logic       sec_en,
  output logic       sec_load,
  output logic       min_load,
  output logic       hour_load,
  output logic [7:0] load_data,
  output logic [1:0] mode,
  output logic       blink
);
  mode_t st, st_nx;
  logic run_en, run_clr, set_en, inc_ok, any_load, sec_tick, blink_tick, blink_clr;
  logic [7:0] field, fmax, data_nx;
  logic [2:0] load_nx;
  always_ff @(posedge clk)
    st <= rst ? MODE_RUN : st_nx;
  always_comb st_nx = mode_key ? mode_t'(st + 2'd1) : st;
  // a mode key clears both dividers, so counting restarts from the edge the mode changes
  always_comb begin
    any_load  = sec_load | min_load | hour_load;
    run_en    = st == MODE_RUN && !mode_key;
    run_clr   = !run_en;
    set_en    = st != MODE_RUN;
    inc_ok    = inc_key && !mode_key && set_en && !any_load;
    blink_clr = !set_en || mode_key || inc_ok;
    field     = st == MODE_SET_HOUR ? hour_q : st == MODE_SET_MIN ? min_q : sec_q;
    fmax      = st == MODE_SET_HOUR ? HOUR_MAX : st == MODE_SET_MIN ? MIN_MAX : SEC_MAX;
    load_nx   = inc_ok ? {st == MODE_SET_HOUR, st == MODE_SET_MIN, st == MODE_SET_SEC} : 3'b000;
    data_nx   = inc_ok ? bcd_inc(field, fmax) : 8'h00;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sec_en <= 1'b0;
      {hour_load, min_load, sec_load} <= 3'b000;
      load_data <= 8'h00;
      blink <= 1'b0;
    end else begin
      sec_en <= sec_tick;
      {hour_load, min_load, sec_load} <= load_nx;
      load_data <= data_nx;
      blink <= blink_clr ? 1'b0 : blink ^ blink_tick;
    end
  assign mode = st;
  tick_div #(.DIV(CLK_DIV)) u_pre (
    .clk(clk), .rst(rst), .clr(run_clr), .en(run_en), .tick(sec_tick)
  );
  tick_div #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .rst(rst), .clr(blink_clr), .en(set_en), .tick(blink_tick)
  );
endmodule

// File: tb/tb_clk_time_ctrl.sv
// tb_clk_time_ctrl: directed scenarios plus random keys against a cycle-age reference model
module tb_clk_time_ctrl;
  logic clk = 1'b0, rst = 1'b1, mode_key = 1'b0, inc_key = 1'b0;
  logic [7:0] sec_q = 8'h00, min_q = 8'h00, hour_q = 8'h00;
  logic sec_en, sec_load, min_load, hour_load, blink;
  logic [7:0] load_data;
  logic [1:0] mode;
  int n_chk = 0, n_pass = 0;
  int m_mode = 0, m_age = 0, m_ld = 0;
  logic [7:0] m_data = 8'h00;

  clk_time_ctrl #(.CLK_DIV(10), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .mode_key(mode_key), .inc_key(inc_key),
    .sec_q(sec_q), .min_q(min_q), .hour_q(hour_q),
    .sec_en(sec_en), .sec_load(sec_load), .min_load(min_load), .hour_load(hour_load),
    .load_data(load_data), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] ref_inc(input logic [7:0] v, input int max);
    int t, u, n;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    if (t > 9 || u > 9 || t * 10 + u == max) return 8'h00;
    n = t * 10 + u + 1;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // model tracks cycles since the last mode change / accepted inc / reset
  task automatic step(input logic mk, input logic ik, input logic r);
    logic acc;
    logic [7:0] f;
    int mx;
    @(negedge clk);
    mode_key = mk;
    inc_key = ik;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_age = 0; m_ld = 0; m_data = 8'h00;
    end else begin
      acc = ik && !mk && m_mode != 0 && m_ld == 0;
      f  = m_mode == 1 ? hour_q : m_mode == 2 ? min_q : sec_q;
      mx = m_mode == 1 ? 23 : 59;
      m_data = acc ? ref_inc(f, mx) : 8'h00;
      m_ld = acc ? m_mode : 0;
      if (mk) begin m_mode = (m_mode + 1) % 4; m_age = 0; end
      else if (acc) m_age = 0;
      else m_age++;
    end
    #1;
    chk("mode", {6'd0, mode}, 8'(m_mode));
    chk("sec_en", {7'd0, sec_en}, {7'd0, m_mode == 0 && m_age > 0 && m_age % 10 == 0});
    chk("loads", {5'd0, hour_load, min_load, sec_load}, m_ld == 0 ? 8'd0 : 8'(1 << (3 - m_ld)));
    chk("blink", {7'd0, blink}, {7'd0, m_mode != 0 && (m_age / 4) % 2 == 1});
    if (m_ld != 0) chk("load_data", load_data, m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_load_data", load_data, 8'h00);
    idle(35);
    hour_q = 8'h23;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("hour_wrap", load_data, 8'h00);
    step(1'b1, 1'b0, 1'b0);
    min_q = 8'h09;
    step(1'b0, 1'b1, 1'b0);
    chk("min_carry", load_data, 8'h10);
    step(1'b0, 1'b1, 1'b0);
    chk("inc_dropped", {7'd0, min_load}, 8'h00);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mode_wins", {5'd0, hour_load, min_load, sec_load}, 8'h00);
    idle(12);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    sec_q = 8'h5A;
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    chk("sec_invalid", load_data, 8'h00);
    idle(12);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    min_q = 8'h41;
    step(1'b0, 1'b1, 1'b0);
    chk("min_inc", load_data, 8'h42);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_cancel_data", load_data, 8'h00);
    chk("rst_cancel_load", {7'd0, min_load}, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      sec_q  = ($urandom_range(3) != 0) ? {4'($urandom_range(5)), 4'($urandom_range(9))} : 8'($urandom);
      min_q  = ($urandom_range(3) != 0) ? {4'($urandom_range(5)), 4'($urandom_range(9))} : 8'($urandom);
      hour_q = ($urandom_range(3) != 0) ? {4'($urandom_range(2)), 4'($urandom_range(9))} : 8'($urandom);
      step($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(299) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
